// File: rtl/attn_col_normalize_pkg.sv
// Shared constants and types for the attention column normalizer.
// The map is an 8x8 packed array: [row][col][bits], matching (8r+c)*16 packing.
package attn_pkg;
  localparam int N    = 8;
  localparam int DW   = 16;
  localparam int FRAC = 16;
  localparam int SUMW = 19;
  localparam int DVDW = 35;
  localparam int QW   = 17;

  typedef enum logic [1:0] {IDLE, SUM, DIV, DONE} state_e;

  localparam logic [DW-1:0] ZERO_COL_WEIGHT = 16'h2000;
  localparam logic [DW-1:0] SAT_WEIGHT      = 16'hFFFF;

  typedef logic [N-1:0][N-1:0][DW-1:0] map_t;
endpackage

// File: rtl/attn_col_normalize_seq_div_u.sv
// Unsigned restoring divider: 35b / 19b -> 17b quotient, done 17 cycles after start.
// The first quotient bit is resolved in the start cycle so 16 more steps finish on time.
module seq_div_u
  import attn_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_i,
  input  logic [DVDW-1:0] dividend_i,
  input  logic [SUMW-1:0] divisor_i,
  output logic [QW-1:0]   quotient_o,
  output logic            done_o,
  output logic            busy_o
);
  logic [SUMW-1:0] rem_q, dsr_q;
  logic [QW-2:0]   dvd_q;
  logic [QW-1:0]   quo_q;
  logic [4:0]      cnt_q;
  logic            busy_q, done_q;

  logic [SUMW-1:0] rem_in, dsr;
  logic            bit_in, ge;
  logic [SUMW:0]   trial, diff;

  // Quotient fits 17 bits because dividend < divisor<<17, so the top 18 bits seed the remainder.
  always_comb begin
    rem_in = start_i ? SUMW'(dividend_i[DVDW-1:QW]) : rem_q;
    bit_in = start_i ? dividend_i[QW-1] : dvd_q[QW-2];
    dsr    = start_i ? divisor_i : dsr_q;
    trial  = {rem_in, bit_in};
    ge     = trial >= {1'b0, dsr};
    diff   = ge ? (trial - {1'b0, dsr}) : trial;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q  <= '0;
      dsr_q  <= '0;
      dvd_q  <= '0;
      quo_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start_i) begin
        rem_q  <= diff[SUMW-1:0];
        dsr_q  <= divisor_i;
        dvd_q  <= dividend_i[QW-2:0];
        quo_q  <= {{(QW-1){1'b0}}, ge};
        cnt_q  <= 5'(QW-1);
        busy_q <= 1'b1;
      end else if (busy_q) begin
        rem_q <= diff[SUMW-1:0];
        dvd_q <= {dvd_q[QW-3:0], 1'b0};
        quo_q <= {quo_q[QW-2:0], ge};
        cnt_q <= cnt_q - 5'd1;
        if (cnt_q == 5'd1) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign quotient_o = quo_q;
  assign done_o     = done_q;
  assign busy_o     = busy_q;
endmodule

// File: rtl/attn_col_normalize.sv
// Column-normalizes an 8x8 score map into Q0.16 weights using one shared divider.
// Zero-sum columns get a uniform 1/8 weight and are flagged in zero_cols.
module attn_col_normalize
  import attn_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [N*N*DW-1:0] attn_map_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [N*N*DW-1:0] norm_map_o,
  output logic [N-1:0]      zero_cols_o,
  output logic              busy_o
);
  state_e          state_q, state_d;
  logic [2:0]      c_q, c_d, r_q, r_d, div_row;
  logic [SUMW-1:0] sum_q, sum_d, col_sum, div_dsr;
  map_t            map_q, map_d, norm_q, norm_d;
  logic [N-1:0]    zc_q, zc_d;

  logic            div_start, div_done, div_busy;
  logic [DVDW-1:0] div_dvd;
  logic [QW-1:0]   div_quo;
  logic [DW-1:0]   wq;

  always_comb begin
    col_sum = '0;
    for (int r = 0; r < N; r++) col_sum = col_sum + SUMW'(map_q[r][c_q]);
  end

  // SUM launches row 0 with the fresh sum; DIV chains the next row with the latched sum.
  assign div_row = (state_q == SUM) ? 3'd0 : r_q + 3'd1;
  assign div_dvd = DVDW'({map_q[div_row][c_q], {FRAC{1'b0}}});
  assign div_dsr = (state_q == SUM) ? col_sum : sum_q;
  assign wq      = div_quo[QW-1] ? SAT_WEIGHT : div_quo[DW-1:0];

  seq_div_u u_div (
    .clk       (clk),
    .rst_n     (rst_n),
    .start_i   (div_start),
    .dividend_i(div_dvd),
    .divisor_i (div_dsr),
    .quotient_o(div_quo),
    .done_o    (div_done),
    .busy_o    (div_busy)
  );

  always_comb begin
    state_d   = state_q;
    c_d       = c_q;
    r_d       = r_q;
    sum_d     = sum_q;
    map_d     = map_q;
    norm_d    = norm_q;
    zc_d      = zc_q;
    div_start = 1'b0;
    unique case (state_q)
      IDLE: if (in_valid_i) begin
        map_d   = attn_map_i;
        zc_d    = '0;
        c_d     = 3'd0;
        state_d = SUM;
      end
      SUM: if (col_sum != '0) begin
        sum_d     = col_sum;
        div_start = 1'b1;
        r_d       = 3'd0;
        state_d   = DIV;
      end else begin
        for (int r = 0; r < N; r++) norm_d[r][c_q] = ZERO_COL_WEIGHT;
        zc_d[c_q] = 1'b1;
        if (c_q == 3'(N-1)) state_d = DONE;
        else c_d = c_q + 3'd1;
      end
      DIV: if (div_done) begin
        norm_d[r_q][c_q] = wq;
        if (r_q != 3'(N-1)) begin
          div_start = 1'b1;
          r_d       = r_q + 3'd1;
        end else if (c_q == 3'(N-1)) begin
          state_d = DONE;
        end else begin
          c_d     = c_q + 3'd1;
          state_d = SUM;
        end
      end
      DONE: if (out_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      c_q     <= '0;
      r_q     <= '0;
      sum_q   <= '0;
      map_q   <= '0;
      norm_q  <= '0;
      zc_q    <= '0;
    end else begin
      state_q <= state_d;
      c_q     <= c_d;
      r_q     <= r_d;
      sum_q   <= sum_d;
      map_q   <= map_d;
      norm_q  <= norm_d;
      zc_q    <= zc_d;
    end
  end

  assign in_ready_o  = (state_q == IDLE);
  assign out_valid_o = (state_q == DONE);
  assign busy_o      = (state_q != IDLE) | div_busy;
  assign norm_map_o  = norm_q;
  assign zero_cols_o = zc_q;
endmodule

// File: tb/tb_attn_col_normalize.sv
// Directed bench for attn_col_normalize: vector table plus stall and mid-run reset sequences.
module tb_attn_col_normalize;
  import attn_pkg::*;

  logic              clk = 1'b0, rst_n = 1'b0;
  logic              in_valid = 1'b0, out_ready = 1'b0;
  logic              in_ready, out_valid, busy;
  logic [N*N*DW-1:0] attn_map = '0, norm_map;
  logic [N-1:0]      zero_cols;

  int checks = 0, errors = 0;

  typedef struct {
    map_t       m;
    map_t       e;
    logic [7:0] zc;
    int         lat;
  } vec_t;
  vec_t vt[6];

  always #5 clk = ~clk;

  attn_col_normalize dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .attn_map_i (attn_map),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .norm_map_o (norm_map),
    .zero_cols_o(zero_cols),
    .busy_o     (busy)
  );

  function automatic map_t set_col(input map_t x, input int c, input logic [15:0] v);
    for (int r = 0; r < N; r++) x[r][c] = v;
    return x;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic chk_map(input string nm, input map_t got, input map_t exp);
    bit shown = 0;
    checks++;
    if (got !== exp) begin
      errors++;
      for (int r = 0; r < N; r++)
        for (int c = 0; c < N; c++)
          if (!shown && got[r][c] !== exp[r][c]) begin
            shown = 1;
            $display("FAIL %s entry(%0d,%0d) got %h expected %h", nm, r, c, got[r][c], exp[r][c]);
          end
    end
  endtask

  task automatic accept(input map_t m);
    int w = 0;
    while (!in_ready && w < 10) begin @(posedge clk); #1; w++; end
    chk("accept_ready", in_ready, 1);
    in_valid = 1'b1;
    attn_map = m;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Cycle 1 is the first cycle after the accept edge.
  task automatic run_to_done(input int i);
    int cyc = 1;
    accept(vt[i].m);
    while (!out_valid && cyc < 3000) begin @(posedge clk); #1; cyc++; end
    chk($sformatf("v%0d_latency", i), cyc, vt[i].lat);
    chk_map($sformatf("v%0d_norm", i), norm_map, vt[i].e);
    chk($sformatf("v%0d_zero_cols", i), zero_cols, vt[i].zc);
    chk($sformatf("v%0d_in_ready_done", i), in_ready, 0);
    chk($sformatf("v%0d_busy_done", i), busy, 1);
  endtask

  task automatic handshake(input string nm);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({nm, "_in_ready_after"}, in_ready, 1);
    chk({nm, "_out_valid_after"}, out_valid, 0);
  endtask

  initial begin
    map_t m, e;
    bit   stable;

    m = '0; m = set_col(m, 0, 16'h1000);
    e = {64{16'h2000}};
    vt[0] = '{m, e, 8'hFE, 145};

    m = '0; m[3][2] = 16'h0005;
    e = {64{16'h2000}}; e = set_col(e, 2, 16'h0000); e[3][2] = 16'hFFFF;
    vt[1] = '{m, e, 8'hFB, 145};

    m = {64{16'h0001}}; m = set_col(m, 0, 16'h0000); m[0][0] = 16'd1; m[1][0] = 16'd3;
    e = {64{16'h2000}}; e = set_col(e, 0, 16'h0000); e[0][0] = 16'h4000; e[1][0] = 16'hC000;
    vt[2] = '{m, e, 8'h00, 1097};

    m = '0; m[0][5] = 16'd1; m[1][5] = 16'd1; m[2][5] = 16'd1;
    e = {64{16'h2000}}; e = set_col(e, 5, 16'h0000);
    e[0][5] = 16'h5555; e[1][5] = 16'h5555; e[2][5] = 16'h5555;
    vt[3] = '{m, e, 8'hDF, 145};

    // Full-scale column exercises the 19-bit sum.
    m = '0; m = set_col(m, 7, 16'hFFFF);
    e = {64{16'h2000}};
    vt[4] = '{m, e, 8'h7F, 145};

    m = '0; m[0][1] = 16'h0001; m[1][1] = 16'hFFFF;
    e = {64{16'h2000}}; e = set_col(e, 1, 16'h0000); e[0][1] = 16'h0001; e[1][1] = 16'hFFFF;
    vt[5] = '{m, e, 8'hFD, 145};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_zero_cols", zero_cols, 0);
    chk_map("rst_norm", norm_map, '0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++) begin
      run_to_done(i);
      handshake($sformatf("v%0d", i));
    end

    // Stall in DONE while a new map is offered.
    run_to_done(1);
    stable = 1;
    for (int k = 0; k < 20; k++) begin
      in_valid = (k == 5);
      attn_map = vt[4].m;
      @(posedge clk); #1;
      if (!out_valid || in_ready || norm_map !== vt[1].e || zero_cols !== vt[1].zc) stable = 0;
    end
    in_valid = 1'b0;
    chk("stall_stable", stable, 1);
    handshake("stall");
    repeat (3) @(posedge clk);
    #1;
    chk("stall_map_ignored_busy", busy, 0);
    chk("stall_map_ignored_ready", in_ready, 1);

    // Reset while column 4 is dividing (column 4 DIV spans cycles 550..685).
    accept(vt[2].m);
    repeat (568) @(posedge clk);
    #1;
    chk("mid_busy", busy, 1);
    chk("mid_partial_00", norm_map[15:0], 16'h4000);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_zero_cols", zero_cols, 0);
    chk_map("mid_rst_norm", norm_map, '0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_to_done(3);
    handshake("post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/attn_col_normalize.md
# attn_col_normalize

Downstream stage of the 8x8 attention core. Accepts one 8x8 map of unsigned 16-bit quantized scores, computes each column's sum, and divides every entry by its column sum to produce Q0.16 normalized weights. A single sequential divider is reused for all entries. Results are returned under a valid/ready handshake.

## Interface
- N, 8, rows/columns of the map (fixed at 8 for this revision)
- DW, 16, score and weight width
- FRAC, 16, fractional bits of output weight (Q0.16)
- clk  in  1  clock
- rst_n  in  1  reset rst_n, asynchronous, active-low; clock clk
- in_valid  in  1  input map valid
- in_ready  out  1  block can accept a map (high only in IDLE)
- attn_map  in  N\*N\*DW  entry (r,c) at bits [(8r+c)\*16 +: 16]
- out_valid  out  1  norm_map valid
- out_ready  in  1  consumer accepts result
- norm_map  out  N\*N\*DW  Q0.16 weight (r,c), same packing as attn_map
- zero_cols  out  N  bit c set when column c summed to 0
- busy  out  1  high in SUM/DIV/DONE

## Operation
- States: IDLE, SUM, DIV, DONE. Reset: IDLE; in_ready=1; out_valid=0; busy=0; norm_map=0; zero_cols=0; column index c=0; row index r=0.
- IDLE: on in_valid&&in_ready, capture attn_map into an internal buffer, clear zero_cols, set c=0, and go to SUM.
- SUM (1 cycle): form a 19-bit zero-extended sum of the 8 entries of column c.
  - If the sum is nonzero: latch it as the divisor, start the divider on row 0 (dividend = entry(0,c)<<16, 35 bits), set r=0, and go to DIV.
  - If the sum is 0: write 16'h2000 (uniform 1/8) to all 8 rows of column c, set zero_cols[c], and go to SUM with c+1, or to DONE if c=7.
- DIV: on divider done, write the quotient to (r,c).
  - If r<7: start row r+1 in the same cycle.
  - If r=7: go to SUM with c+1, or to DONE if c=7.
- Quotient rules: quotient is 17 bits and truncated (no rounding). A quotient of 65536 or more (entry equals the column sum) saturates to 16'hFFFF.
- DONE: out_valid=1, with norm_map and zero_cols held stable. On out_ready, go to IDLE the next cycle; in_ready rises in that cycle.
- norm_map updates progressively during SUM/DIV. It is only meaningful while out_valid=1.
- in_valid outside IDLE is ignored, and the buffer is not overwritten.
- Asynchronous reset at any state aborts the current operation, restores all reset values, and stops the divider.

## Timing
- Divider: start sampled at cycle t, done pulse with quotient at t+17.
- Costs: a nonzero column takes 1 + 8\*17 = 137 cycles; a zero column takes 1 cycle.
- Latency: with the accept edge at cycle 0, out_valid rises at 1 + sum of column costs.
  - All columns nonzero: cycle 1097.
  - All columns zero: cycle 9.
- Throughput: 1 map per (latency + 1 handshake cycle + 1 IDLE cycle).
- No combinational path from in_valid or out_ready to any output except through registered state.

## Structure
- Shared package attn_pkg holds:
  - N, DW, FRAC, and SUMW=19
  - the state enum {IDLE, SUM, DIV, DONE}
  - ZERO_COL_WEIGHT=16'h2000 and SAT_WEIGHT=16'hFFFF
- One sub-module: seq_div_u, an unsigned restoring divider.
  - 35-bit dividend, 19-bit divisor, 17-bit quotient.
  - Ports: start, done, busy; fixed 17-cycle latency.
- Top level holds the FSM, the input buffer, the column sum, and the norm_map/zero_cols registers.

## Test plan
- Column 0 all 16'h1000, others 0 -> column 0 = 16'h2000 ×8; columns 1-7 = 16'h2000; zero_cols=8'hFE; out_valid at cycle 145.
- Column 2: row 3 = 16'h0005, rest 0 -> (3,2)=16'hFFFF (saturated), other rows of column 2 = 0; zero_cols[2]=0.
- Column 0 rows 0/1 = 1/3, rest 0 -> 16'h4000 / 16'hC000; with every column nonzero, out_valid at cycle 1097.
- Column of three 1s, rest 0 -> each 16'h5555 (truncation), zeros elsewhere in the column.
- Hold out_ready=0 for 20 cycles in DONE and pulse in_valid -> norm_map and out_valid stable, in_ready=0, new map ignored; after the handshake, in_ready=1 the next cycle.
- Assert rst_n low mid-DIV (column 4) -> out_valid, busy, norm_map and zero_cols immediately 0, in_ready=1; a subsequent map processes correctly from column 0.
